// File: rtl/regfile_writeback.sv
// regfile_writeback: write-side initiator for the register file.
// Merges ALU and load-unit results (valid/ready), buffers them in an in-order
// queue of QDEPTH entries and retires at most one register write per cycle.
// Reports pending-write hazards for two decode source addresses.
// Optional build macro WB_BYPASS_EN: an ALU result arriving while the queue
// is empty goes straight to the write port (one cycle earlier).
module regfile_writeback #(
  parameter int DEPTH  = 32,
  parameter int BITS   = 64,
  parameter int QDEPTH = 4,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [BITS-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_rd,
  input  logic [BITS-1:0]   ld_data,
  output logic [ADDR_W-1:0] addressw,
  output logic [BITS-1:0]   writeData,
  output logic              writeEn,
  input  logic [ADDR_W-1:0] query1,
  input  logic [ADDR_W-1:0] query2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              busy
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_QDEPTH = CNT_W'(QDEPTH);

  // Queue storage; entry validity is derived from the pointers and count.
  logic [ADDR_W-1:0] r_q_rd   [QDEPTH];
  logic [BITS-1:0]   r_q_data [QDEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic [CNT_W-1:0]  w_free;
  logic              w_alu_acc;
  logic              w_ld_acc;
  logic              w_alu_byp;
  logic              w_alu_enq;
  logic              w_ld_enq;
  logic              w_deq;
  logic              w_we0;
  logic              w_we1;
  logic [ADDR_W-1:0] w_rd0;
  logic [BITS-1:0]   w_data0;
  logic [PTR_W-1:0]  w_wr_ptr1;
  logic [1:0]        w_enq_n;
  logic [QDEPTH-1:0] w_hit1;
  logic [QDEPTH-1:0] w_hit2;

  // Readiness uses the registered count only; a same-cycle pop earns no credit.
  // The load needs two free slots when the ALU may take one in the same cycle.
  assign w_free    = C_QDEPTH - r_count;
  assign alu_ready = (w_free >= CNT_W'(1));
  assign ld_ready  = alu_valid ? (w_free >= CNT_W'(2)) : (w_free >= CNT_W'(1));
  assign w_alu_acc = alu_valid && alu_ready;
  assign w_ld_acc  = ld_valid && ld_ready;

`ifdef WB_BYPASS_EN
  assign w_alu_byp = w_alu_acc && (alu_rd != '0) && (r_count == '0);
`else
  assign w_alu_byp = 1'b0;
`endif

  // Writes to x0 complete the handshake but never occupy a slot.
  assign w_alu_enq = w_alu_acc && (alu_rd != '0) && !w_alu_byp;
  assign w_ld_enq  = w_ld_acc && (ld_rd != '0);
  assign w_deq     = (r_count != '0);

  // Slot r_wr_ptr takes the ALU entry if present, otherwise the load; the
  // load goes one slot further when both enqueue together.
  assign w_we0     = w_alu_enq || w_ld_enq;
  assign w_we1     = w_alu_enq && w_ld_enq;
  assign w_rd0     = w_alu_enq ? alu_rd : ld_rd;
  assign w_data0   = w_alu_enq ? alu_data : ld_data;
  assign w_wr_ptr1 = r_wr_ptr + PTR_W'(1);
  assign w_enq_n   = {1'b0, w_alu_enq} + {1'b0, w_ld_enq};

  // Queue storage write (no reset needed: validity comes from count).
  always_ff @(posedge clk) begin
    if (w_we0) begin
      r_q_rd[r_wr_ptr]   <= w_rd0;
      r_q_data[r_wr_ptr] <= w_data0;
    end
    if (w_we1) begin
      r_q_rd[w_wr_ptr1]   <= ld_rd;
      r_q_data[w_wr_ptr1] <= ld_data;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo QDEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_count  <= r_count + CNT_W'(w_enq_n) - CNT_W'(w_deq);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_enq_n);
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_deq);
    end
  end

  // Write port: pop the head, or take a bypassed ALU result, else idle (hold).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addressw  <= '0;
      writeData <= '0;
      writeEn   <= 1'b0;
    end else if (w_deq) begin
      addressw  <= r_q_rd[r_rd_ptr];
      writeData <= r_q_data[r_rd_ptr];
      writeEn   <= 1'b1;
    end else if (w_alu_byp) begin
      addressw  <= alu_rd;
      writeData <= alu_data;
      writeEn   <= 1'b1;
    end else begin
      writeEn   <= 1'b0;
    end
  end

  // Per-slot hazard match: slot is live when its distance from the head is
  // below the occupancy count.
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
    logic [PTR_W-1:0] w_off;
    logic             w_live;
    assign w_off      = PTR_W'(gi) - r_rd_ptr;
    assign w_live     = ({1'b0, w_off} < r_count);
    assign w_hit1[gi] = w_live && (r_q_rd[gi] == query1);
    assign w_hit2[gi] = w_live && (r_q_rd[gi] == query2);
  end

  assign hazard1 = (query1 != '0) && ((|w_hit1) || (writeEn && (addressw == query1)));
  assign hazard2 = (query2 != '0) && ((|w_hit2) || (writeEn && (addressw == query2)));
  assign busy    = (r_count != '0) || writeEn;

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed scenarios followed by
// randomized producer traffic, checked every cycle against a queue-level
// reference model of the writeback behaviour.
`timescale 1ns/1ps
module tb_regfile_writeback;

  localparam int QD = 4;
  localparam int AW = 5;
  localparam int BW = 64;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, ld_valid;
  logic          alu_ready, ld_ready;
  logic [AW-1:0] alu_rd, ld_rd, addressw, query1, query2;
  logic [BW-1:0] alu_data, ld_data, writeData;
  logic          writeEn, hazard1, hazard2, busy;

  regfile_writeback #(.DEPTH(32), .BITS(BW), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .addressw(addressw), .writeData(writeData), .writeEn(writeEn),
    .query1(query1), .query2(query2), .hazard1(hazard1), .hazard2(hazard2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [BW-1:0] data;
  } ent_t;

  // Reference model: pending entries in order, plus the write-port state.
  ent_t          mq[$];
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [BW-1:0] m_data;

  // Producer stimulus queues: the front item is presented until accepted.
  ent_t aq[$];
  ent_t lq[$];

  bit rand_q;
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  function automatic bit m_pending(logic [AW-1:0] q);
    if (q == '0) return 1'b0;
    if (m_we && m_addr == q) return 1'b1;
    foreach (mq[i]) if (mq[i].rd == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("writeEn",   64'(writeEn),   64'(m_we));
    chk("addressw",  64'(addressw),  64'(m_addr));
    chk("writeData", writeData,      m_data);
    chk("alu_ready", 64'(alu_ready), 64'(mq.size() < QD));
    chk("ld_ready",  64'(ld_ready),  64'(alu_valid ? (mq.size() <= QD - 2) : (mq.size() < QD)));
    chk("hazard1",   64'(hazard1),   64'(m_pending(query1)));
    chk("hazard2",   64'(hazard2),   64'(m_pending(query2)));
    chk("busy",      64'(busy),      64'((mq.size() != 0) || m_we));
  endtask

  // One clock: present producers, step the model at the edge, check at +1.
  task automatic cycle();
    bit   a_acc, l_acc, a_enq;
    ent_t a, l, e;
    alu_valid = (aq.size() > 0);
    if (alu_valid) begin alu_rd = aq[0].rd; alu_data = aq[0].data; end
    ld_valid = (lq.size() > 0);
    if (ld_valid) begin ld_rd = lq[0].rd; ld_data = lq[0].data; end
    if (rand_q) begin
      query1 = AW'($urandom_range(0, 9));
      query2 = AW'($urandom_range(0, 31));
    end
    a_acc = alu_valid && (mq.size() < QD);
    l_acc = ld_valid && (alu_valid ? (mq.size() <= QD - 2) : (mq.size() < QD));
    a = '{rd: alu_rd, data: alu_data};
    l = '{rd: ld_rd, data: ld_data};
    a_enq = a_acc && (a.rd != '0);
    @(posedge clk);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_we = 1'b1; m_addr = e.rd; m_data = e.data;
    end else if (BYP && a_enq) begin
      m_we = 1'b1; m_addr = a.rd; m_data = a.data;
      a_enq = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    if (a_enq) mq.push_back(a);
    if (l_acc && l.rd != '0) mq.push_back(l);
    if (a_acc) void'(aq.pop_front());
    if (l_acc) void'(lq.pop_front());
    #1;
    check_all();
  endtask

  task automatic model_reset();
    mq.delete();
    m_we = 1'b0; m_addr = '0; m_data = '0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
    query1 = '0; query2 = '0; rand_q = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;

    // Single ALU write: latency check then hazard on rd 5 clears
    query1 = 5; query2 = 4;
    aq.push_back('{rd: 5, data: 64'hDEAD_BEEF});
    n = 0;
    do begin cycle(); n++; end while (!writeEn && n < 10);
    chk("latency", 64'(n), BYP ? 64'd1 : 64'd2);
    chk("single_addr", 64'(addressw), 64'd5);
    chk("single_data", writeData, 64'hDEAD_BEEF);
    repeat (2) cycle();
    chk("single_hz_clear", 64'(hazard1), 64'd0);

    // Simultaneous producers to the same rd
    query1 = 3; query2 = 0;
    aq.push_back('{rd: 3, data: 64'd1});
    lq.push_back('{rd: 3, data: 64'd2});
    repeat (5) cycle();

    // Backpressure: fill the queue from both producers
    for (int k = 0; k < 5; k++) aq.push_back('{rd: AW'(10 + k), data: 64'(100 + k)});
    for (int k = 0; k < 4; k++) lq.push_back('{rd: AW'(20 + k), data: 64'(200 + k)});
    query1 = 12; query2 = 21;
    repeat (14) cycle();

    // x0 drop
    query1 = 0; query2 = 0;
    aq.push_back('{rd: 0, data: 64'd77});
    repeat (3) cycle();

    // Back-to-back stream of eight writes
    for (int k = 1; k <= 8; k++) aq.push_back('{rd: AW'(k), data: 64'(k * 11)});
    query1 = 8; query2 = 1;
    repeat (12) cycle();

    // Randomized traffic with hold-until-accepted producers
    rand_q = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if (aq.size() < 3 && ($urandom % 3) != 0)
        aq.push_back('{rd: AW'($urandom_range(0, 7)), data: {$urandom, $urandom}});
      if (lq.size() < 3 && ($urandom % 2) != 0)
        lq.push_back('{rd: AW'($urandom_range(0, 7)), data: {$urandom, $urandom}});
      cycle();
    end
    n = 0;
    while ((aq.size() > 0 || lq.size() > 0 || mq.size() > 0 || m_we) && n < 50) begin
      cycle(); n++;
    end
    chk("drain_done", 64'(busy), 64'd0);

    // Reset mid-drain with three entries queued
    for (int k = 0; k < 2; k++) begin
      aq.push_back('{rd: AW'(24 + k), data: 64'(300 + k)});
      lq.push_back('{rd: AW'(28 + k), data: 64'(400 + k)});
    end
    repeat (2) cycle();
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
    aq.delete(); lq.delete();
    model_reset();
    #1 check_all();
    @(posedge clk);
    #1 check_all();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side initiator for the register file: drives its write port (addressw, writeData, writeEn).
- Merges results from two producers, the single-cycle ALU and the multi-cycle load unit, each on a valid/ready handshake.
- Buffers results in a small in-order queue and retires at most one register write per cycle.
- Reports pending-write hazards for two source addresses so decode can stall until the write lands.

Parameters:
- DEPTH, 32, number of architectural registers; ADDR_W = $clog2(DEPTH).
- BITS, 64, data width.
- QDEPTH, 4, writeback queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid is also high.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  BITS  ALU result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load result accepted this cycle when ld_valid is also high.
- ld_rd  in  ADDR_W  load destination register.
- ld_data  in  BITS  load data.
- addressw  out  ADDR_W  register-file write address.
- writeData  out  BITS  register-file write data.
- writeEn  out  1  register-file write strobe, one cycle per write.
- query1, query2  in  ADDR_W  source addresses checked for pending writes.
- hazard1, hazard2  out  1  a write to the corresponding query address is still pending.
- busy  out  1  queue not empty or writeEn high.

Behaviour:
- Reset:
  - rst_n low clears the queue (count=0, read and write pointers 0) and sets addressw=0, writeData=0, writeEn=0.
  - This applies immediately, at any point, including mid-queue; all pending entries are dropped.
- Handshake:
  - Transfer occurs on a rising edge where valid and ready are both high.
  - Producers hold rd/data stable while valid is high and ready is low.
- Free-slot accounting:
  - free = QDEPTH - count, using the registered count only; no credit for a same-cycle dequeue.
  - alu_ready = (free >= 1).
  - ld_ready = (free >= 2) when alu_valid is high, else (free >= 1).
- Ordering:
  - On simultaneous acceptance, the ALU entry is enqueued first, then the load entry.
  - Writes retire strictly in enqueue order.
  - Two entries for the same rd both retire, in order; the last one wins in the register file.
- x0 suppression: an accepted transfer with rd==0 completes the handshake but is not enqueued.
- Dequeue:
  - Each edge where count>0, the head entry is popped into the output registers and writeEn=1 for the following cycle.
  - Otherwise writeEn=0, and addressw/writeData hold their last values.
- Latency: a transfer accepted at edge N with an empty queue gives writeEn high between edges N+1 and N+2. Sustained throughput is 1 write per cycle.
- Count update: count_next = count + enq_count (0..2) - deq (0/1).
  - Never exceeds QDEPTH; never underflows.
  - Pointers wrap modulo QDEPTH.
- Full queue: both ready signals are low; nothing is lost.
- Hazard:
  - hazardX = (queryX != 0) AND (queryX matches the rd of any valid queue entry, OR (writeEn and addressw == queryX)).
  - Hazard is purely combinational from state; incoming same-cycle transfers are excluded.
- busy = (count != 0) | writeEn.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined:
  - When count==0, an accepted non-x0 ALU transfer loads the output registers directly at the same edge.
  - writeEn is then high between edges N and N+1 (latency 1).
  - A load accepted in the same cycle is enqueued and retires next, so order is preserved.
  - Hazard logic is unchanged.
- Undefined: every entry passes through the queue; latency 2 as above.

Test Plan:
- Reset mid-drain: enqueue 3 entries, then pulse rst_n low for 1 cycle -> writeEn=0 immediately; no further writes; busy=0; ready signals high afterward.
- Single ALU write: alu_rd=5, alu_data=64'hDEAD_BEEF accepted at edge N -> writeEn=1, addressw=5, writeData=64'hDEAD_BEEF in the cycle after edge N+1 (cycle after edge N with WB_BYPASS_EN); then hazard1=0 with query1=5.
- Simultaneous producers: alu_rd=3/data=1 and ld_rd=3/data=2 in the same cycle on an empty queue -> two consecutive writes to rd 3, data 1 then 2; hazard on 3 stays high until the second writeEn cycle ends.
- Backpressure: hold alu_valid high with 5 distinct rds while the queue is full (QDEPTH=4) -> alu_ready=0 on full; all 5 writes appear in order with none lost; ld_ready=0 when free=1 and alu_valid is high.
- x0 drop: alu_rd=0 accepted -> alu_ready=1; no writeEn; count unchanged; hazard1=0 with query1=0.
- Back-to-back stream of 8 ALU results with rd 1..8 -> 8 consecutive writeEn cycles; pointers wrap cleanly after 4; busy falls the cycle after the last write.
